// File: rtl/instr_loader.sv
// Boot loader: parses a [len16][payload][csum8] byte stream into 32-bit instruction-memory writes.
// Latency: one cycle from the 4th byte of a word to imem_we; one cycle from the checksum byte to done/err.
// Backpressure: in_ready is a pure state decode, so a byte is accepted on every cycle with in_valid while loading.
module instr_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]           o_imem_wdata,
  output logic                  o_cpu_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  // Largest word count that fits in instruction memory.
  localparam logic [16:0] MAX_WORDS = 17'd1 << (ADDR_WIDTH - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_len_lo;
  logic [15:0]           r_len;
  logic [1:0]            r_byte_cnt;
  logic [15:0]           r_word_idx;
  logic [23:0]           r_asm;
  logic [7:0]            r_sum;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_done;
  logic                  r_err;

  logic                  w_xfer;
  logic                  w_start_ok;
  logic [15:0]           w_len;
  logic                  w_oversize;
  logic                  w_word_end;
  logic                  w_last_word;

  assign w_xfer      = i_in_valid && o_in_ready;
  assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_len       = {i_in_data, r_len_lo};
  assign w_oversize  = {1'b0, w_len} > MAX_WORDS;
  assign w_word_end  = (r_state == S_DATA) && w_xfer && (r_byte_cnt == 2'd3);
  assign w_last_word = (r_word_idx == (r_len - 16'd1));

  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_done       = r_done;
  assign o_err        = r_err;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs; the core stays in reset unless the last load verified.
  always_comb begin
    w_next     = r_state;
    o_in_ready = 1'b0;
    o_busy     = 1'b0;
    o_cpu_rst  = 1'b1;
    case (r_state)
      S_IDLE, S_ERR: begin
        if (w_start_ok) w_next = S_LEN0;
      end
      S_DONE: begin
        o_cpu_rst = 1'b0;
        if (w_start_ok) w_next = S_LEN0;
      end
      S_LEN0: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_xfer) w_next = S_LEN1;
      end
      S_LEN1: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_xfer) begin
          if (w_oversize)         w_next = S_ERR;
          else if (w_len == '0)   w_next = S_CSUM;
          else                    w_next = S_DATA;
        end
      end
      S_DATA: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_word_end && w_last_word) w_next = S_CSUM;
      end
      S_CSUM: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_xfer) w_next = (i_in_data == r_sum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, running checksum, write strobe and result flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len_lo   <= '0;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_word_idx <= '0;
      r_asm      <= '0;
      r_sum      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_byte_cnt <= '0;
        r_word_idx <= '0;
        r_sum      <= '0;
      end
      if ((r_state == S_LEN0) && w_xfer) begin
        r_len_lo <= i_in_data;
      end
      if ((r_state == S_LEN1) && w_xfer) begin
        r_len <= w_len;
        if (w_oversize) r_err <= 1'b1;
      end
      if ((r_state == S_DATA) && w_xfer) begin
        r_sum      <= r_sum + i_in_data;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        // Bytes arrive LSB first, so shift each new one in from the top.
        r_asm      <= {i_in_data, r_asm[23:8]};
        if (r_byte_cnt == 2'd3) begin
          r_we       <= 1'b1;
          r_addr     <= {r_word_idx[ADDR_WIDTH-3:0], 2'b00};
          r_wdata    <= {i_in_data, r_asm};
          r_word_idx <= r_word_idx + 16'd1;
        end
      end
      if ((r_state == S_CSUM) && w_xfer) begin
        if (i_in_data == r_sum) r_done <= 1'b1;
        else                    r_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: expected writes are queued as stimulus is driven
// and checked by a monitor as the DUT emits them; status outputs are checked inline.
module tb_instr_loader;

  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp;
  int  n_fail;
  int  n_writes;

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_in_data    (in_data),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_cpu_rst    (cpu_rst),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every cycle with a write strobe must match the next queued write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), e.addr);
        check("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited;
    while (gaps && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) check("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_nominal_writes();
    wr_t w;
    w.addr = 32'h000; w.data = 32'h12345678; exp_q.push_back(w);
    w.addr = 32'h004; w.data = 32'hDEADBEEF; exp_q.push_back(w);
  endtask

  // Sends the two-word nominal image; bad_csum corrupts the final byte.
  task automatic send_nominal(input bit bad_csum, input bit gaps);
    logic [31:0] words [2];
    logic [7:0]  sum;
    words[0] = 32'h12345678;
    words[1] = 32'hDEADBEEF;
    sum = 8'h00;
    push_nominal_writes();
    send_byte(8'h02, gaps);
    send_byte(8'h00, gaps);
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(words[w][8*b +: 8], gaps);
        sum = sum + words[w][8*b +: 8];
      end
    end
    send_byte(bad_csum ? sum + 8'h01 : sum, gaps);
  endtask

  task automatic check_outputs(input string tag, input logic rdy, input logic cr,
                               input logic bs, input logic dn, input logic er);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
    check({tag, "_cpu_rst"},  32'(cpu_rst),  32'(cr));
    check({tag, "_busy"},     32'(busy),     32'(bs));
    check({tag, "_done"},     32'(done),     32'(dn));
    check({tag, "_err"},      32'(err),      32'(er));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 6; i++) tick();
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    n_cmp = 0; n_fail = 0; n_writes = 0;
    rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset values.
    check_outputs("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_we",    32'(imem_we),   32'd0);
    check("reset_addr",  32'(imem_addr), 32'd0);
    check("reset_wdata", imem_wdata,     32'd0);

    // Nominal load; start takes effect the following cycle.
    pulse_start();
    check_outputs("start", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_nominal(1'b0, 1'b0);
    check_outputs("nominal", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("nominal");
    check("nominal_write_count", 32'(n_writes), 32'd2);

    // Restart from DONE, with a start pulse mid-load that must be ignored.
    pulse_start();
    check_outputs("restart", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push_nominal_writes();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h78, 1'b0);
    pulse_start();
    check("busy_start_busy", 32'(busy), 32'd1);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    pulse_start();
    send_byte(8'hAD, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'h4C, 1'b0);
    check_outputs("busy_start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("busy_start");

    // Bad checksum: writes still happen, result is an error.
    pulse_start();
    send_nominal(1'b1, 1'b0);
    check_outputs("bad_csum", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drain("bad_csum");

    // Oversize count (257 words > 256).
    wr_before = n_writes;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check_outputs("oversize", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drain("oversize");
    check("oversize_no_write", 32'(n_writes), 32'(wr_before));

    // Empty image.
    wr_before = n_writes;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("empty_in_csum_busy", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b0);
    check_outputs("empty", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("empty");
    check("empty_no_write", 32'(n_writes), 32'(wr_before));

    // Nominal load with random input gaps.
    pulse_start();
    send_nominal(1'b0, 1'b1);
    check_outputs("gaps", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("gaps");

    // Reset after 5 bytes, then a full reload starting again at address 0.
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    wr_before = n_writes;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outputs("midrst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst_we",    32'(imem_we),   32'd0);
    check("midrst_addr",  32'(imem_addr), 32'd0);
    check("midrst_wdata", imem_wdata,     32'd0);
    drain("midrst");
    check("midrst_no_write", 32'(n_writes), 32'(wr_before));
    pulse_start();
    send_nominal(1'b0, 1'b0);
    check_outputs("reload", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("reload");

    // start and rst together: reset wins.
    start = 1'b1;
    rst   = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    check_outputs("start_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader that fills the CPU's instruction memory from a byte stream and holds the core in reset until the image is complete and verified. It sits between an external byte source (UART receiver, debug bridge or testbench) and the write port of the instruction memory. It is the writer side of the instruction-memory interface that the fetch path reads. Its `cpu_rst` output is ORed into the core's reset.

## Interface
- `ADDR_WIDTH`, default 10: byte-address width of instruction memory. Capacity `MAX_WORDS = 2^(ADDR_WIDTH-2)`.
- `clk  in  1`: single clock.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: one-cycle request to begin a load. Honoured only in IDLE, DONE or ERR.
- `in_data  in  8`: stream byte.
- `in_valid  in  1`: `in_data` is valid.
- `in_ready  out  1`: loader accepts a byte. A transfer occurs on any cycle with `in_valid && in_ready`.
- `imem_we  out  1`: one-cycle instruction-memory write strobe.
- `imem_addr  out  ADDR_WIDTH`: byte address, word aligned (bits [1:0] = 0).
- `imem_wdata  out  32`: instruction word.
- `cpu_rst  out  1`: holds the core in reset. High except in DONE.
- `busy  out  1`: a load is in progress (LEN0..CSUM).
- `done  out  1`: last load succeeded.
- `err  out  1`: last load failed.

## Operation
- Stream format, in order:
  - word count N: 2 bytes, little-endian, 16 bits.
  - 4·N payload bytes: little-endian words; the first byte is bits [7:0].
  - 1 checksum byte = sum of all payload bytes mod 256. Header bytes are excluded from the sum.
- States:
  - IDLE -(start)-> LEN0
  - LEN0 -(byte)-> LEN1
  - LEN1 -(byte)-> one of:
    - ERR if N > MAX_WORDS
    - CSUM if N = 0
    - DATA otherwise
  - DATA -(4·N-th byte)-> CSUM
  - CSUM -(byte)-> DONE if checksum matches, else ERR
  - DONE or ERR -(start)-> LEN0
- On `start` (entering LEN0), clear the following: `done`, `err`, byte counter, word index, running sum. `cpu_rst` goes to 1.
- `in_ready` is 1 in LEN0, LEN1, DATA and CSUM, and 0 in IDLE, DONE and ERR. It is a combinational decode of state; no stall within a state.
- `start` is ignored while `busy`.
- DATA:
  - Each accepted byte is shifted into the word assembly register and added to the running sum (8-bit, wraps).
  - On the 4th byte of a word, drive `imem_we=1` for exactly one cycle with `imem_addr = word_idx<<2` and `imem_wdata = {b3,b2,b1,b0}`.
  - After the write, `word_idx` increments. `word_idx` never exceeds N-1 for a write, so no address wrap is possible.
- Writes already issued are not undone on a checksum failure. ERR keeps `cpu_rst=1`.
- `rst` in any state, including mid-word, returns to IDLE with all outputs at their reset values. Partial words are discarded.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready=0`, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`
  - `cpu_rst=1`, `busy=0`, `done=0`, `err=0`
- `start` sampled at edge t: state = LEN0, `busy=1` and `in_ready=1` from cycle t+1.
- 4th byte of a word accepted at edge k: `imem_we=1` during cycle k+1 only. `imem_addr` and `imem_wdata` are registered and stable from k+1 until the next write.
- Sustained rate: 1 byte per cycle. Back-to-back words give `imem_we` every 4th cycle.
- Checksum byte accepted at edge k: from cycle k+1, `busy=0` and one of:
  - match: `done=1`, `cpu_rst=0`
  - mismatch: `err=1`, `cpu_rst=1`
- 2nd length byte accepted with N > MAX_WORDS at edge k: `err=1` and `in_ready=0` from k+1. No writes occur.
- `start` and `rst` in the same cycle: `rst` wins.

## Test plan
- Nominal load:
  - Stimulus: `start`, then 02 00, 78 56 34 12, EF BE AD DE, 4C.
  - Required: two writes, (addr 0x000, 0x12345678) then (0x004, 0xDEADBEEF), each `imem_we` exactly one cycle. Then `done=1`, `cpu_rst=0`, `busy=0`.
- Bad checksum:
  - Stimulus: same stream with final byte 4D.
  - Required: both writes occur; `err=1`, `done=0`, `cpu_rst=1`.
- Oversize count:
  - Stimulus: `ADDR_WIDTH=10`, header 01 01 (N=257).
  - Required: `err=1` the cycle after the 2nd byte, `in_ready=0`, no `imem_we`.
- Empty image and backpressure:
  - Stimulus: header 00 00 plus checksum 00.
  - Required: `done=1` with no writes.
  - Stimulus: repeat the nominal load with `in_valid` randomly deasserted ~50% of cycles.
  - Required: identical writes and result.
- Reset mid-load:
  - Stimulus: assert `rst` after 5 bytes of the nominal stream.
  - Required: all outputs at reset values the next cycle and no further writes. A subsequent full nominal load succeeds, with the first write again at addr 0.
- Restart after completion:
  - Stimulus: `start` while in DONE.
  - Required: `done=0`, `cpu_rst=1`, `busy=1` next cycle. `start` pulsed while `busy` has no effect on counters.
